// File: rtl/noc_defs.sv
// -----------------------------------------------------------------------------
// noc_defs
// Shared router definitions: default port count, port indices, tail-flag
// position helper, and the output-arbiter FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package noc_defs;

    // Default number of input FIFOs competing for one output port.
    localparam int NUM_PORTS = 5;

    // Default flit width; the tail flag is always the flit MSB.
    localparam int DATA_WIDTH = 8;

    // Port indices of a 5-port mesh router.
    localparam int PORT_LOCAL = 0;
    localparam int PORT_NORTH = 1;
    localparam int PORT_EAST  = 2;
    localparam int PORT_SOUTH = 3;
    localparam int PORT_WEST  = 4;

    // Tail flag position for a given flit width.
    function automatic int tail_bit(input int dw);
        return dw - 1;
    endfunction

    localparam int TAIL_BIT = tail_bit(DATA_WIDTH);

    // Pointer width able to index n ports (at least one bit).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Output arbiter FSM states.
    //   ST_IDLE : output free, searching for a new owner
    //   ST_ARM  : owner locked, waiting to issue a read
    //   ST_CAPT : read issued last cycle, capturing the FIFO's registered data
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_CAPT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational rotating-priority search. Returns the first requesting port
// after rr_ptr, wrapping modulo N, as a one-hot vector (all-zero when no
// request is present).
// Ports:
//   req    in  [N-1:0]      request vector
//   rr_ptr in  [PTR_W-1:0]  last port served; search starts at rr_ptr+1
//   gnt    out [N-1:0]      one-hot winner
// -----------------------------------------------------------------------------
module rr_arbiter
    import noc_defs::*;
#(
    parameter int N     = NUM_PORTS,
    parameter int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     gnt
);

    logic             found;
    logic [PTR_W-1:0] idx;
    int               pos;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        // Visit rr_ptr+1 .. rr_ptr+N; the last visit is rr_ptr itself, so
        // the previous owner only wins when nobody else is asking.
        for (int k = 1; k <= N; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = PTR_W'(pos);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_output_arbiter.sv
// -----------------------------------------------------------------------------
// router_output_arbiter
// Output-port arbiter of a wormhole router. Locks the output to one input
// FIFO for a whole packet (head to tail flit), reading one flit every two
// cycles and forwarding it downstream with a registered write strobe.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   en         in   global enable; low freezes state
//   req        in   [NUM_PORTS-1:0] head packet of FIFO i wants this output
//   fifo_empty in   [NUM_PORTS-1:0] empty flag of FIFO i
//   fifo_data  in   [NUM_PORTS*DATA_WIDTH-1:0] registered FIFO data, slice i
//   down_full  in   downstream buffer full
//   fifo_read  out  [NUM_PORTS-1:0] one-hot read strobe (combinational)
//   grant      out  [NUM_PORTS-1:0] registered one-hot owner, zero when free
//   Data_out   out  [DATA_WIDTH-1:0] registered flit to downstream
//   valid_out  out  one-cycle downstream write strobe
//   busy       out  output port currently owned
//
// Handshake: fifo_read in cycle t pops the FIFO; its registered data is valid
// in t+1 (CAPT), is registered here, and appears with valid_out in t+2.
// valid_out is a pure strobe: downstream has no back-pressure on a flit
// already in flight; down_full only stops new reads from being issued.
// -----------------------------------------------------------------------------
module router_output_arbiter
    import noc_defs::*;
#(
    parameter int DATA_WIDTH = noc_defs::DATA_WIDTH,
    parameter int NUM_PORTS  = noc_defs::NUM_PORTS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS-1:0]            fifo_empty,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_data,
    input  logic                            down_full,
    output logic [NUM_PORTS-1:0]            fifo_read,
    output logic [NUM_PORTS-1:0]            grant,
    output logic [DATA_WIDTH-1:0]           Data_out,
    output logic                            valid_out,
    output logic                            busy
);

    localparam int PTR_W    = ptr_width(NUM_PORTS);
    localparam int TAIL_POS = tail_bit(DATA_WIDTH);

    arb_state_e             state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic                   valid_out_q, valid_out_d;

    logic [NUM_PORTS-1:0]   cand;
    logic [NUM_PORTS-1:0]   winner;
    logic                   owner_ready;
    logic [DATA_WIDTH-1:0]  cap_flit;
    logic [PTR_W-1:0]       owner_idx;

    // A port is only a candidate when it both routes here and has a flit.
    assign cand = req & ~fifo_empty;

    rr_arbiter #(
        .N     (NUM_PORTS),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req    (cand),
        .rr_ptr (rr_ptr_q),
        .gnt    (winner)
    );

    // Owner's slice and index, selected by the one-hot grant (AND-OR mux).
    always_comb begin
        cap_flit  = '0;
        owner_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q[i]) begin
                cap_flit  = cap_flit | fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
                owner_idx = PTR_W'(i);
            end
        end
    end

    assign owner_ready = |(grant_q & ~fifo_empty);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        fifo_read   = '0;

        if (!rst && en) begin
            case (state_q)
                ST_IDLE: begin
                    if (|cand) begin
                        grant_d = winner;
                        state_d = ST_ARM;
                    end
                end
                ST_ARM: begin
                    // Lock is held while the owner is empty or downstream full;
                    // other ports are never considered here.
                    if (owner_ready && !down_full) begin
                        fifo_read = grant_q;
                        state_d   = ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    data_out_d  = cap_flit;
                    valid_out_d = 1'b1;
                    if (cap_flit[TAIL_POS]) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        rr_ptr_d = owner_idx;
                    end else begin
                        state_d = ST_ARM;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= PTR_W'(NUM_PORTS - 1);
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign grant     = grant_q;
    assign Data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign busy      = |grant_q;

endmodule

// File: tb/tb_router_output_arbiter.sv
// -----------------------------------------------------------------------------
// tb_router_output_arbiter
// Directed bench for router_output_arbiter. A behavioural FIFO per input port
// feeds the DUT; delivered flits are compared against an expected queue.
// -----------------------------------------------------------------------------
module tb_router_output_arbiter;

    localparam int DW = 8;
    localparam int NP = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [NP-1:0]      req;
    logic [NP-1:0]      fifo_empty;
    logic [NP*DW-1:0]   fifo_data;
    logic               down_full;
    logic [NP-1:0]      fifo_read;
    logic [NP-1:0]      grant;
    logic [DW-1:0]      data_out;
    logic               valid_out;
    logic               busy;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    logic [DW-1:0] q3[$];
    logic [DW-1:0] q4[$];
    logic [DW-1:0] exp_q[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_valid = 1'b0;

    // ---------------------------------------------------------------- clock
    always #5 clk = ~clk;

    router_output_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .down_full  (down_full),
        .fifo_read  (fifo_read),
        .grant      (grant),
        .Data_out   (data_out),
        .valid_out  (valid_out),
        .busy       (busy)
    );

    // ---------------------------------------------------------------- checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- FIFO model
    task automatic refresh_empty();
        fifo_empty = {q4.size() == 0, q3.size() == 0, q2.size() == 0,
                      q1.size() == 0, q0.size() == 0};
    endtask

    task automatic push(input int p, input logic [DW-1:0] v);
        case (p)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            3: q3.push_back(v);
            default: q4.push_back(v);
        endcase
        refresh_empty();
    endtask

    task automatic pop_into(input int p);
        logic [DW-1:0] v;
        v = '0;
        if (fifo_empty[p]) begin
            check("read_while_empty", {31'd0, fifo_empty[p]}, 0);
        end else begin
            case (p)
                0: v = q0.pop_front();
                1: v = q1.pop_front();
                2: v = q2.pop_front();
                3: v = q3.pop_front();
                default: v = q4.pop_front();
            endcase
            fifo_data[p*DW +: DW] = v;
        end
    endtask

    // One clock: sample the read strobe, let the edge pass, then update FIFOs
    // like a registered-output FIFO would.
    task automatic cycle();
        logic [NP-1:0] rd;
        #1;
        rd = fifo_read;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (rd[p]) pop_into(p);
        end
        refresh_empty();
        #1;
    endtask

    task automatic wait_release(input string tag);
        for (int n = 0; n < 40 && grant != '0; n++) cycle();
        check(tag, grant, 0);
    endtask

    task automatic wait_grant(input string tag, input logic [NP-1:0] exp);
        for (int n = 0; n < 30 && grant == '0; n++) cycle();
        check(tag, grant, exp);
        wait_release({tag, "_release"});
    endtask

    task automatic run_until_idle(input string tag);
        for (int n = 0; n < 60 && (grant != '0 || exp_q.size() != 0); n++) cycle();
        check({tag, "_grant_free"}, grant, 0);
        check({tag, "_all_delivered"}, exp_q.size(), 0);
    endtask

    // ---------------------------------------------------------------- scoreboard
    always @(negedge clk) begin
        if (fifo_read != '0) begin
            check("read_onehot", {31'd0, $onehot(fifo_read)}, 1);
        end
        if (valid_out) begin
            check("valid_single_cycle", {31'd0, prev_valid}, 0);
            if (exp_q.size() == 0) check("spurious_valid", {31'd0, valid_out}, 0);
            else                   check("flit_data", data_out, exp_q.pop_front());
        end
        prev_valid = valid_out;
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        req       = '0;
        down_full = 1'b0;
        fifo_data = '0;
        refresh_empty();

        // Reset state
        cycle();
        cycle();
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid_out, 0);
        check("rst_data", data_out, 0);
        check("rst_read", fifo_read, 0);
        rst = 1'b0;

        // Two-flit packet from port 0
        push(0, 8'h11); push(0, 8'h92);
        exp_q.push_back(8'h11); exp_q.push_back(8'h92);
        req = 5'b00001;
        cycle();
        check("s1_grant", grant, 5'b00001);
        check("s1_busy", busy, 1);
        check("s1_first_read", fifo_read, 5'b00001);
        run_until_idle("s1");
        req = '0;

        // Round robin among ports 1 and 2; port 1 re-requests
        push(1, 8'h81); push(1, 8'h81); push(2, 8'h81);
        exp_q.push_back(8'h81); exp_q.push_back(8'h81); exp_q.push_back(8'h81);
        req = 5'b00110;
        wait_grant("s2_port1", 5'b00010);
        wait_grant("s2_port2", 5'b00100);
        wait_grant("s2_port1_again", 5'b00010);
        run_until_idle("s2");
        req = '0;

        // Downstream full for 5 cycles in ARM
        push(3, 8'h83);
        exp_q.push_back(8'h83);
        req       = 5'b01000;
        down_full = 1'b1;
        cycle();
        check("s3_grant", grant, 5'b01000);
        for (int i = 0; i < 5; i++) begin
            check("s3_no_read", fifo_read, 0);
            cycle();
            check("s3_no_valid", valid_out, 0);
        end
        down_full = 1'b0;
        #1;
        check("s3_read_after_full", fifo_read, 5'b01000);
        run_until_idle("s3");
        req = '0;

        // Owner runs empty mid-packet while others request
        push(4, 8'h05); push(0, 8'h81); push(1, 8'h81);
        exp_q.push_back(8'h05);
        req = 5'b10011;
        cycle();
        check("s4_grant", grant, 5'b10000);
        req = 5'b00011;
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("s4_lock_held", grant, 5'b10000);
            check("s4_no_read", fifo_read, 0);
        end
        push(4, 8'h85);
        exp_q.push_back(8'h85); exp_q.push_back(8'h81); exp_q.push_back(8'h81);
        wait_release("s4_tail_release");
        wait_grant("s4_next_port0", 5'b00001);
        wait_grant("s4_next_port1", 5'b00010);
        run_until_idle("s4");
        req = '0;

        // Reset while capturing a mid-packet flit
        push(2, 8'h02); push(2, 8'h03); push(2, 8'h84);
        req = 5'b00100;
        cycle();
        check("s5_grant", grant, 5'b00100);
        cycle();
        rst = 1'b1;
        #1;
        check("s5_rst_no_read", fifo_read, 0);
        cycle();
        check("s5_rst_grant", grant, 0);
        check("s5_rst_valid", valid_out, 0);
        check("s5_rst_data", data_out, 0);
        check("s5_rst_busy", busy, 0);
        rst = 1'b0;
        q2.delete();
        refresh_empty();
        push(1, 8'h81); push(3, 8'h81);
        exp_q.push_back(8'h81); exp_q.push_back(8'h81);
        req = 5'b01010;
        wait_grant("s5_lowest_first", 5'b00010);
        wait_grant("s5_then_port3", 5'b01000);
        run_until_idle("s5");
        req = '0;

        // Enable low for 3 cycles in ARM
        push(0, 8'h10); push(0, 8'h91);
        exp_q.push_back(8'h10); exp_q.push_back(8'h91);
        req = 5'b00001;
        cycle();
        check("s6_grant", grant, 5'b00001);
        en = 1'b0;
        #1;
        check("s6_en_no_read", fifo_read, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("s6_frozen_grant", grant, 5'b00001);
            check("s6_frozen_valid", valid_out, 0);
            check("s6_frozen_data", data_out, 8'h81);
            check("s6_frozen_read", fifo_read, 0);
        end
        en = 1'b1;
        #1;
        check("s6_resume_read", fifo_read, 5'b00001);
        run_until_idle("s6");
        req = '0;

        cycle();
        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
